uart_tx_gen2: RTL and testbench

UART_TX_GEN2 -- requirements
Module: uart_tx_gen2

---
 rtl/uart_tx_gen2.sv | 247 ++++++++++++++++++++++++
 tb/tb_uart_tx_gen2.sv | 394 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_gen2.sv
// uart_tx_gen2: buffered UART transmitter, runtime frame format.
// FIFO front end, oversampled bit timing and break generation.
module uart_tx_gen2 #(
  parameter int DATA_MAX   = 9,
  parameter int FIFO_DEPTH = 16,
  parameter int OVERSAMPLE = 16
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          ov_baud_rt_i,
  input  logic                          enable_i,
  input  logic [DATA_MAX-1:0]           data_i,
  input  logic                          write_i,
  input  logic                          flush_i,
  input  logic [3:0]                    data_width_i,
  input  logic [2:0]                    parity_mode_i,
  input  logic [1:0]                    stop_bits_i,
  input  logic                          msb_first_i,
  input  logic                          break_req_i,
  output logic                          tx_o,
  output logic                          tx_done_o,
  output logic                          idle_o,
  output logic                          fifo_empty_o,
  output logic                          fifo_full_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o,
  output logic                          overflow_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(2 * OVERSAMPLE);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;
  localparam logic [2:0] S_BREAK  = 3'd5;

  localparam logic [CW-1:0] LIM_ONE  = CW'(OVERSAMPLE - 1);
  localparam logic [CW-1:0] LIM_HALF = CW'(3 * OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] LIM_TWO  = CW'(2 * OVERSAMPLE - 1);
  localparam logic [CW-1:0] TICK_ONE = CW'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW + 1)'(FIFO_DEPTH);
  localparam logic [3:0]    W_MIN    = 4'd5;
  localparam logic [3:0]    W_MAX    = 4'(DATA_MAX);

  logic [DATA_MAX-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]       wr_ptr_q, rd_ptr_q;
  logic [AW:0]         count_q;
  logic                ovf_q;
  logic                empty, full, push, pop, drop;

  logic [2:0]          state_q, state_d;
  logic [CW-1:0]       tick_q, tick_d, lim;
  logic [3:0]          idx_q, idx_d;
  logic [DATA_MAX-1:0] data_q, data_m, shifted;
  logic [3:0]          width_q, width_c, pos;
  logic                par_en_q, par_bit_q;
  logic                par_en_c, par_bit_c;
  logic [1:0]          stop_q;
  logic                msb_q;
  logic                tx_q, done_q;
  logic                line, bit_end, can_go, load;

  assign empty  = (count_q == '0);
  assign full   = (count_q == CNT_FULL);
  assign can_go = !empty && enable_i && !break_req_i;
  assign pop    = load;
  assign push   = write_i && !flush_i && (!full || pop);
  assign drop   = write_i && !flush_i && full && !pop;

  // FIFO storage; no reset needed, occupancy guards reads
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= data_i;
  end

  // FIFO pointers, occupancy and overflow pulse
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      ovf_q <= drop;
      if (flush_i) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        count_q  <= '0;
      end else begin
        if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
        if (pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
        case ({push, pop})
          2'b10:   count_q <= count_q + CNT_ONE;
          2'b01:   count_q <= count_q - CNT_ONE;
          default: count_q <= count_q;
        endcase
      end
    end
  end

  // Frame setup from the FIFO head and live config inputs
  always_comb begin
    width_c = data_width_i;
    if (data_width_i < W_MIN) width_c = W_MIN;
    else if (data_width_i > W_MAX) width_c = W_MAX;
    data_m = '0;
    for (int i = 0; i < DATA_MAX; i++)
      data_m[i] = mem_q[rd_ptr_q][i] && (i < int'(width_c));
    par_en_c  = 1'b1;
    par_bit_c = 1'b0;
    case (parity_mode_i)
      3'd1:    par_bit_c = ^data_m;
      3'd2:    par_bit_c = ~^data_m;
      3'd3:    par_bit_c = 1'b1;
      3'd4:    par_bit_c = 1'b0;
      default: par_en_c  = 1'b0;
    endcase
  end

  // Tick limit of the current bit; only stop bits vary
  always_comb begin
    lim = LIM_ONE;
    if (state_q == S_STOP) begin
      case (stop_q)
        2'd1:    lim = LIM_HALF;
        2'd2:    lim = LIM_TWO;
        default: lim = LIM_ONE;
      endcase
    end
  end

  assign bit_end = ov_baud_rt_i && (tick_q == lim);
  assign pos     = msb_q ? (width_q - 4'd1 - idx_q) : idx_q;
  assign shifted = data_q >> pos;

  // Frame sequencer: next state, tick/bit counters, line level
  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    idx_d   = idx_q;
    load    = 1'b0;
    line    = 1'b1;
    if (ov_baud_rt_i) tick_d = bit_end ? '0 : tick_q + TICK_ONE;
    unique case (state_q)
      S_IDLE: begin
        tick_d = '0;
        idx_d  = '0;
        if (break_req_i) begin
          state_d = S_BREAK;
        end else if (can_go) begin
          state_d = S_START;
          load    = 1'b1;
        end
      end
      S_START: begin
        line = 1'b0;
        if (bit_end) state_d = S_DATA;
      end
      S_DATA: begin
        line = shifted[0];
        if (bit_end) begin
          if (idx_q == width_q - 4'd1) begin
            idx_d   = '0;
            state_d = par_en_q ? S_PARITY : S_STOP;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
      end
      S_PARITY: begin
        line = par_bit_q;
        if (bit_end) state_d = S_STOP;
      end
      S_STOP: begin
        if (bit_end) begin
          if (can_go) begin
            state_d = S_START;
            load    = 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_BREAK: begin
        // hold low while requested, then one bit time of mark
        if (break_req_i) begin
          line   = 1'b0;
          tick_d = '0;
        end else if (bit_end) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        tick_d  = '0;
      end
    endcase
  end

  // Sequencer state, registered line and end-of-frame pulse
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      tick_q  <= '0;
      idx_q   <= '0;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      idx_q   <= idx_d;
      tx_q    <= line;
      done_q  <= (state_q == S_STOP) && bit_end;
    end
  end

  // Per-frame configuration captured as the frame starts
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      data_q    <= '0;
      width_q   <= W_MIN;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
      stop_q    <= 2'd0;
      msb_q     <= 1'b0;
    end else if (load) begin
      data_q    <= data_m;
      width_q   <= width_c;
      par_en_q  <= par_en_c;
      par_bit_q <= par_bit_c;
      stop_q    <= stop_bits_i;
      msb_q     <= msb_first_i;
    end
  end

  assign tx_o         = tx_q;
  assign tx_done_o    = done_q;
  assign idle_o       = (state_q == S_IDLE);
  assign fifo_empty_o = empty;
  assign fifo_full_o  = full;
  assign fifo_count_o = count_q;
  assign overflow_o   = ovf_q;

endmodule

// File: tb/tb_uart_tx_gen2.sv
// tb_uart_tx_gen2: table vectors, directed corner cases and
// randomized frames against a per-cycle line model.
module tb_uart_tx_gen2;

  localparam int DMAX  = 9;
  localparam int DEPTH = 16;
  localparam int OS    = 16;

  logic       clk = 1'b0;
  logic       rst, ov, en, wr, fl, msb, brk;
  logic [8:0] din;
  logic [3:0] wid;
  logic [2:0] par;
  logic [1:0] stp;
  logic       tx, done, idle, empty, full, ovf;
  logic [4:0] cnt;

  int checks = 0;
  int errors = 0;
  int tick_per = 1;
  int tick_cnt = 0;
  int t;
  int n;
  int bad;
  logic [8:0] rd;

  logic exp_q[$];
  int   mdata[$];

  typedef struct {
    logic [3:0] w;
    logic [2:0] p;
    logic [1:0] s;
    logic       m;
    logic [8:0] d;
    string      pat;
    int         stop_cyc;
  } vec_t;
  vec_t vecs[7];

  uart_tx_gen2 #(
    .DATA_MAX(DMAX), .FIFO_DEPTH(DEPTH), .OVERSAMPLE(OS)
  ) dut (
    .clk_i(clk), .rst_i(rst), .ov_baud_rt_i(ov),
    .enable_i(en), .data_i(din), .write_i(wr),
    .flush_i(fl), .data_width_i(wid),
    .parity_mode_i(par), .stop_bits_i(stp),
    .msb_first_i(msb), .break_req_i(brk),
    .tx_o(tx), .tx_done_o(done), .idle_o(idle),
    .fifo_empty_o(empty), .fifo_full_o(full),
    .fifo_count_o(cnt), .overflow_o(ovf)
  );

  always #5 clk = ~clk;

  initial begin
    ov = 1'b0;
    forever begin
      @(negedge clk);
      tick_cnt++;
      ov = (tick_cnt % tick_per) == 0;
    end
  end

  task automatic chk(input string name, input int got,
                     input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d",
               name, got, want);
    end
  endtask

  function automatic void expand_pat(string pat, int stop_cyc);
    exp_q.delete();
    repeat (OS) exp_q.push_back(1'b0);
    for (int i = 0; i < pat.len(); i++)
      repeat (OS) exp_q.push_back(pat[i] == 8'h31);
    repeat (stop_cyc) exp_q.push_back(1'b1);
  endfunction

  // Expected per-cycle line for one frame, tick on every cycle.
  function automatic void model_frame(int d, int w_in, int pm,
                                      int sb, int m);
    int w, ones, b, stopc;
    w = (w_in < 5) ? 5 : ((w_in > DMAX) ? DMAX : w_in);
    exp_q.delete();
    ones = 0;
    repeat (OS) exp_q.push_back(1'b0);
    for (int k = 0; k < w; k++) begin
      ones += (d >> k) & 1;
      b = (m != 0) ? ((d >> (w - 1 - k)) & 1) : ((d >> k) & 1);
      repeat (OS) exp_q.push_back(b[0]);
    end
    case (pm)
      1:       b = ones % 2;
      2:       b = 1 - ones % 2;
      3:       b = 1;
      4:       b = 0;
      default: b = -1;
    endcase
    if (b >= 0) repeat (OS) exp_q.push_back(b[0]);
    stopc = (sb == 1) ? OS * 3 / 2 : ((sb == 2) ? 2 * OS : OS);
    repeat (stopc) exp_q.push_back(1'b1);
  endfunction

  task automatic put(input logic [8:0] d);
    din = d;
    wr  = 1'b1;
    @(negedge clk);
    wr  = 1'b0;
  endtask

  task automatic wait_start(output int tw);
    tw = 0;
    while (tx !== 1'b0 && tw < 3000) begin
      @(negedge clk);
      tw++;
    end
  endtask

  task automatic wait_level(input logic v, input string name);
    int tw;
    tw = 0;
    while (tx !== v && tw < 3000) begin
      @(negedge clk);
      tw++;
    end
    chk({name, " reach level"}, int'(tx === v), 1);
  endtask

  task automatic cmp_frame(input string name);
    int nb, first, dbad;
    nb = 0;
    first = -1;
    dbad = 0;
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i > 0) @(negedge clk);
      if (tx !== exp_q[i]) begin
        nb++;
        if (first < 0) first = i;
      end
      if (done !== (i == exp_q.size() - 1)) dbad++;
    end
    checks++;
    if (nb != 0) begin
      errors++;
      $display("FAIL %s wave: got %0d wrong cycles of %0d (first %0d) expected 0",
               name, nb, exp_q.size(), first);
    end
    chk({name, " done pulse"}, dbad, 0);
  endtask

  task automatic run_frame(input string name, output int tw);
    wait_start(tw);
    if (tw >= 3000) begin
      checks++;
      errors++;
      $display("FAIL %s start: got none in %0d cycles expected start bit",
               name, tw);
    end else begin
      cmp_frame(name);
    end
  endtask

  task automatic wait_idle(input string name);
    int tw;
    tw = 0;
    while ((idle !== 1'b1 || empty !== 1'b1) && tw < 5000) begin
      @(negedge clk);
      tw++;
    end
    chk({name, " idle"}, int'(idle === 1'b1), 1);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; wr = 1'b0; fl = 1'b0;
    msb = 1'b0; brk = 1'b0; din = '0;
    wid = 4'd8; par = 3'd1; stp = 2'd0;

    vecs[0] = '{4'd8,  3'd1, 2'd0, 1'b0, 9'h0A5, "101001010",  16};
    vecs[1] = '{4'd9,  3'd2, 2'd2, 1'b1, 9'h1FF, "1111111110", 32};
    vecs[2] = '{4'd3,  3'd0, 2'd3, 1'b0, 9'h1F3, "11001",      16};
    vecs[3] = '{4'd15, 3'd3, 2'd1, 1'b1, 9'h0A5, "0101001011", 24};
    vecs[4] = '{4'd6,  3'd4, 2'd0, 1'b1, 9'h1ED, "1011010",    16};
    vecs[5] = '{4'd7,  3'd6, 2'd2, 1'b0, 9'h055, "1010101",    32};
    vecs[6] = '{4'd5,  3'd2, 2'd0, 1'b0, 9'h016, "011010",     16};

    repeat (3) @(negedge clk);
    chk("rst tx", int'(tx), 1);
    chk("rst idle", int'(idle), 1);
    chk("rst done", int'(done), 0);
    chk("rst ovf", int'(ovf), 0);
    chk("rst empty", int'(empty), 1);
    chk("rst full", int'(full), 0);
    chk("rst count", int'(cnt), 0);
    rst = 1'b0;
    en  = 1'b1;
    @(negedge clk);

    // table vectors; config scrambled mid-frame must not matter
    for (int k = 0; k < 7; k++) begin
      wid = vecs[k].w;
      par = vecs[k].p;
      stp = vecs[k].s;
      msb = vecs[k].m;
      expand_pat(vecs[k].pat, vecs[k].stop_cyc);
      put(vecs[k].d);
      fork
        run_frame($sformatf("vec%0d", k), t);
        begin
          repeat (30) @(negedge clk);
          wid = 4'($urandom);
          par = 3'($urandom);
          stp = 2'($urandom);
          msb = 1'($urandom);
        end
      join
      repeat (3) @(negedge clk);
    end

    // fill, overflow, write on full with same-cycle pop
    wid = 4'd8; par = 3'd0; stp = 2'd0; msb = 1'b0;
    en = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      rd = 9'(i * 29 + 3);
      mdata.push_back(int'(rd));
      put(rd);
    end
    chk("fill count", int'(cnt), 16);
    chk("fill full", int'(full), 1);
    chk("fill empty", int'(empty), 0);
    put(9'h1AA);
    chk("ovf pulse", int'(ovf), 1);
    chk("ovf count", int'(cnt), 16);
    @(negedge clk);
    chk("ovf one cycle", int'(ovf), 0);
    en = 1'b1;
    mdata.push_back(int'(9'h1AB));
    put(9'h1AB);
    chk("full+pop ovf", int'(ovf), 0);
    chk("full+pop count", int'(cnt), 16);
    for (int f = 0; f < DEPTH + 1; f++) begin
      model_frame(mdata.pop_front(), 8, 0, 0, 0);
      run_frame($sformatf("b2b%0d", f), t);
      if (f > 0) chk($sformatf("b2b%0d gap", f), t, 1);
    end
    wait_idle("b2b");
    chk("b2b count", int'(cnt), 0);

    // flush beats a same-cycle write
    en = 1'b0;
    put(9'h011);
    put(9'h022);
    put(9'h033);
    chk("pre-flush count", int'(cnt), 3);
    din = 9'h044; wr = 1'b1; fl = 1'b1;
    @(negedge clk);
    wr = 1'b0; fl = 1'b0;
    chk("flush count", int'(cnt), 0);
    chk("flush empty", int'(empty), 1);
    @(negedge clk);
    chk("flush no ovf", int'(ovf), 0);

    // one-and-half stop bits, tick every 4 cycles
    tick_per = 4;
    stp = 2'd1;
    en = 1'b1;
    put(9'h000);
    wait_level(1'b0, "stop15 start");
    wait_level(1'b1, "stop15 stop");
    n = 0;
    while (n < 500) begin
      n++;
      if (done === 1'b1) break;
      @(negedge clk);
    end
    chk("stop15 cycles", n, 96);
    tick_per = 1;
    stp = 2'd0;
    wait_idle("stop15");

    // break requested mid-frame waits for the frame to finish
    put(9'h0F0);
    put(9'h03C);
    model_frame(9'h0F0, 8, 0, 0, 0);
    fork
      begin
        run_frame("brkA", t);
        wait_level(1'b0, "brk low");
        bad = 0;
        while (brk === 1'b1) begin
          if (tx !== 1'b0) bad++;
          @(negedge clk);
        end
        chk("brk held low", bad, 0);
        wait_level(1'b1, "brk release");
        n = 0;
        while (tx === 1'b1 && n < 100) begin
          n++;
          @(negedge clk);
        end
        // 16 ticks of mark, then one IDLE cycle before START
        chk("brk mark cycles", n, 17);
        model_frame(9'h03C, 8, 0, 0, 0);
        run_frame("brkB", t);
      end
      begin
        n = 0;
        while (idle === 1'b1 && n < 100) begin
          n++;
          @(negedge clk);
        end
        repeat (60) @(negedge clk);
        brk = 1'b1;
        repeat (200) @(negedge clk);
        brk = 1'b0;
      end
    join
    wait_idle("brk");

    // reset in the middle of DATA with entries queued
    en = 1'b0;
    put(9'h0AA);
    put(9'h055);
    put(9'h0CC);
    put(9'h033);
    en = 1'b1;
    n = 0;
    while (idle === 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
    end
    repeat (40) @(negedge clk);
    chk("mid count", int'(cnt), 3);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort tx", int'(tx), 1);
    chk("abort count", int'(cnt), 0);
    chk("abort idle", int'(idle), 1);
    chk("abort empty", int'(empty), 1);
    bad = 0;
    n = 0;
    repeat (300) begin
      if (done === 1'b1) bad++;
      if (tx !== 1'b1) n++;
      @(negedge clk);
    end
    chk("abort no done", bad, 0);
    chk("abort line high", n, 0);

    // randomized formats and data against the model
    for (int sg = 0; sg < 6; sg++) begin
      wid = 4'($urandom);
      par = 3'($urandom);
      stp = 2'($urandom);
      msb = 1'($urandom);
      fork
        begin
          for (int j = 0; j < 8; j++) begin
            repeat ($urandom_range(0, 250)) @(negedge clk);
            rd = 9'($urandom);
            mdata.push_back(int'(rd));
            put(rd);
          end
        end
        begin
          for (int j = 0; j < 8; j++) begin
            wait_start(t);
            if (t >= 3000) begin
              checks++;
              errors++;
              $display("FAIL rnd%0d.%0d start: got none expected start bit",
                       sg, j);
            end else begin
              model_frame(mdata.pop_front(), int'(wid), int'(par),
                          int'(stp), int'(msb));
              cmp_frame($sformatf("rnd%0d.%0d", sg, j));
            end
          end
        end
      join
      wait_idle($sformatf("rnd%0d", sg));
      mdata.delete();
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
